latch_dump_sender: RTL and testbench

- Debug-path block directly downstream of the pipeline latch selector.
- On a start pulse it sweeps every defined latch-select code in order and waits for the selector's registered 32-bit word.
- It captures the word and streams it as 4 bytes to the UART transmitter through a start/done handshake.
- Gives the debug unit a complete snapshot of all IF/ID/EX/MEM/WB latches per request.

---
 rtl/latch_dump_sender.sv | 142 ++++++++++++++
 tb/tb_latch_dump_sender.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_dump_sender.sv
// latch_dump_sender: sweeps every pipeline-latch select code, captures the
// registered selector word and streams it as four bytes to the UART transmitter.
module latch_dump_sender #(
  parameter int MUX_LATENCY    = 1,
  parameter int BYTE_LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] sel_data,
  input  logic        tx_done,
  output logic [6:0]  mux_sel,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done
);

  localparam int WAIT_W = $clog2(MUX_LATENCY + 2);
  localparam logic [6:0] LAST_CODE = 7'h41;

  typedef enum logic [2:0] {IDLE, SEL, CAPTURE, SEND, WAIT_TX, NEXT, FIN} stateT;

  stateT             state, nextState;
  logic [2:0]        stage, nextStage;
  logic [3:0]        offset, nextOffset;
  logic [1:0]        byteIdx, byteSel;
  logic [WAIT_W-1:0] waitCnt;
  logic [31:0]       capWord;
  logic [6:0]        muxSel;
  logic              selDone;

  function automatic logic [3:0] lastOffset(input logic [2:0] s);
    case (s)
      3'd0:    return 4'd1;
      3'd1:    return 4'd5;
      3'd2:    return 4'd5;
      3'd3:    return 4'd3;
      default: return 4'd1;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState  = state;
    tx_start   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    selDone    = (waitCnt == WAIT_W'(MUX_LATENCY));
    nextStage  = stage;
    nextOffset = offset + 4'd1;
    if (offset == lastOffset(stage)) begin
      nextStage  = stage + 3'd1;
      nextOffset = '0;
    end
    byteSel = (BYTE_LSB_FIRST != 0) ? byteIdx : ~byteIdx;
    tx_data = capWord[{byteSel, 3'b000} +: 8];
    case (state)
      IDLE:    if (start) nextState = SEL;
      SEL: begin
        busy = 1'b1;
        if (selDone) nextState = CAPTURE;
      end
      CAPTURE: begin
        busy      = 1'b1;
        nextState = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        tx_start  = 1'b1;
        nextState = WAIT_TX;
      end
      WAIT_TX: begin
        busy = 1'b1;
        if (tx_done) nextState = (byteIdx == 2'd3) ? NEXT : SEND;
      end
      NEXT: begin
        busy      = 1'b1;
        nextState = (muxSel == LAST_CODE) ? FIN : SEL;
      end
      FIN: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // abort also masks start while idle
    if (abort) nextState = IDLE;
  end

  // The word is latched on the edge that leaves SEL, i.e. MUX_LATENCY+1 edges
  // after mux_sel moved; CAPTURE then presents byte 0 for the following SEND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage   <= '0;
      offset  <= '0;
      byteIdx <= '0;
      waitCnt <= '0;
      capWord <= '0;
      muxSel  <= '0;
    end else if (!abort) begin
      case (state)
        IDLE: begin
          if (start) begin
            stage   <= '0;
            offset  <= '0;
            muxSel  <= '0;
            waitCnt <= '0;
          end
        end
        SEL: begin
          if (selDone) begin
            capWord <= sel_data;
            byteIdx <= '0;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        WAIT_TX: begin
          if (tx_done && byteIdx != 2'd3) byteIdx <= byteIdx + 2'd1;
        end
        NEXT: begin
          if (muxSel != LAST_CODE) begin
            stage  <= nextStage;
            offset <= nextOffset;
            muxSel <= {nextStage, nextOffset};
          end
        end
        default: ;
      endcase
    end
  end

  assign mux_sel = muxSel;

endmodule

// File: tb/tb_latch_dump_sender.sv
// Bench for latch_dump_sender: four instances (default, MSB-first, 2-cycle
// selector, and 1-cycle latency against a 2-cycle selector to expose stale capture).
module tb_latch_dump_sender;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic startA   = 1'b0;
  logic startB   = 1'b0;
  logic abortA   = 1'b0;
  logic spurDone = 1'b0;
  logic logClr   = 1'b1;
  int   nChecks  = 0;
  int   nErrors  = 0;

  logic [6:0] codeList [20] = '{7'h00, 7'h01, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14,
                                7'h15, 7'h20, 7'h21, 7'h22, 7'h23, 7'h24, 7'h25,
                                7'h30, 7'h31, 7'h32, 7'h33, 7'h40, 7'h41};

  typedef struct {
    logic [6:0]      code;
    logic [3:0][7:0] bytes;
  } vecT;
  vecT tab [20];

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int k, input logic [6:0] c);
    if (k == 0) return {25'h0, c};
    if (k == 1) return 32'hDEADBEEF;
    return {1'b0, c, 8'hA5, 1'b0, ~c, 8'h3C};
  endfunction

  function automatic logic [7:0] expByte(input int k, input int n);
    int w = n / 4;
    int b = n % 4;
    logic [6:0]  src;
    logic [31:0] word;
    src  = (k == 3 && w > 0) ? codeList[w-1] : codeList[w];
    word = pat(k, src);
    if (k == 1) return word[8*(3-b) +: 8];
    return word[8*b +: 8];
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g
    logic [6:0]  muxSel;
    logic        txStart, busy, done, txDone;
    logic [7:0]  txData;
    logic [31:0] selData = '0;
    logic [31:0] d1 = '0;
    logic [2:0]  sh = '0;
    logic [7:0]  logByte [128];
    logic [6:0]  logSel [128];
    int          n = 0;
    int          doneCnt = 0;
    int          badDone = 0;

    assign txDone = sh[2] | ((i == 0) ? spurDone : 1'b0);

    latch_dump_sender #(
      .MUX_LATENCY   ((i == 2) ? 2 : 1),
      .BYTE_LSB_FIRST((i == 1) ? 0 : 1)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   ((i == 0) ? startA : startB),
      .abort   ((i == 0) ? abortA : 1'b0),
      .sel_data(selData),
      .tx_done (txDone),
      .mux_sel (muxSel),
      .tx_start(txStart),
      .tx_data (txData),
      .busy    (busy),
      .done    (done)
    );

    // selector model (1 or 2 register stages) and UART answering 3 cycles after tx_start
    always @(posedge clk) begin
      d1      <= pat(i, muxSel);
      selData <= (i >= 2) ? d1 : pat(i, muxSel);
      sh      <= {sh[1:0], txStart};
    end

    always @(negedge clk) begin
      if (logClr) begin
        n = 0; doneCnt = 0; badDone = 0;
      end else begin
        if (txStart) begin
          if (n < 128) begin
            logByte[n] = txData;
            logSel[n]  = muxSel;
          end
          n++;
        end
        if (done) begin
          doneCnt++;
          if (busy) badDone++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clearLogs;
    logClr = 1'b1;
    repeat (2) @(negedge clk);
    logClr = 1'b0;
  endtask

  task automatic checkDumpA(input string tag);
    check({tag, " count"}, 32'(g[0].n), 32'd80);
    check({tag, " done"}, 32'(g[0].doneCnt), 32'd1);
    check({tag, " busy at done"}, 32'(g[0].badDone), 32'd0);
    for (int w = 0; w < 20; w++)
      for (int b = 0; b < 4; b++) begin
        check($sformatf("%s byte %0d", tag, 4*w+b), 32'(g[0].logByte[4*w+b]), 32'(tab[w].bytes[b]));
        check($sformatf("%s sel %0d", tag, 4*w+b), 32'(g[0].logSel[4*w+b]), 32'(tab[w].code));
      end
  endtask

  task automatic pulseStart(input bit withOthers);
    startA = 1'b1;
    startB = withOthers;
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic runDumpA(input string tag, input bit inject, input bit withOthers);
    int k;
    clearLogs();
    pulseStart(withOthers);
    check({tag, " busy after start"}, 32'(g[0].busy), 32'd1);
    check({tag, " first sel"}, 32'(g[0].muxSel), 32'h00);
    if (inject) begin
      for (k = 0; k < 1000; k++) begin
        if (g[0].muxSel == 7'h13) break;
        @(negedge clk);
      end
      if (k == 1000) check({tag, " wait 0x13 timeout"}, 32'd0, 32'd1);
      startA = 1'b1;
      @(negedge clk);
      startA   = 1'b0;
      spurDone = 1'b1;
      @(negedge clk);
      spurDone = 1'b0;
    end
    for (k = 0; k < 3000 && g[0].doneCnt == 0; k++) @(negedge clk);
    if (g[0].doneCnt == 0) check({tag, " done timeout"}, 32'd0, 32'd1);
    repeat (40) @(negedge clk);
    checkDumpA(tag);
    check({tag, " busy idle"}, 32'(g[0].busy), 32'd0);
    check({tag, " final sel"}, 32'(g[0].muxSel), 32'h41);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hits;
    for (int w = 0; w < 20; w++) begin
      tab[w].code  = codeList[w];
      tab[w].bytes = {8'h00, 8'h00, 8'h00, {1'b0, codeList[w]}};
    end

    #1 rst = 1'b0;
    #1;
    check("reset mux_sel", 32'(g[0].muxSel), 32'h00);
    check("reset tx_start", 32'(g[0].txStart), 32'd0);
    check("reset tx_data", 32'(g[0].txData), 32'h00);
    check("reset busy", 32'(g[0].busy), 32'd0);
    check("reset done", 32'(g[0].done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // start together with abort while idle is ignored
    startA = 1'b1;
    abortA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    abortA = 1'b0;
    check("start+abort idle busy", 32'(g[0].busy), 32'd0);
    repeat (3) @(negedge clk);
    check("start+abort idle tx", 32'(g[0].txStart), 32'd0);

    runDumpA("full", 1'b0, 1'b1);
    check("msb count", 32'(g[1].n), 32'd80);
    check("msb done", 32'(g[1].doneCnt), 32'd1);
    check("lat2 count", 32'(g[2].n), 32'd80);
    check("lat2 done", 32'(g[2].doneCnt), 32'd1);
    check("stale count", 32'(g[3].n), 32'd80);
    check("stale done", 32'(g[3].doneCnt), 32'd1);
    for (int n = 0; n < 80; n++) begin
      check($sformatf("msb byte %0d", n), 32'(g[1].logByte[n]), 32'(expByte(1, n)));
      check($sformatf("lat2 byte %0d", n), 32'(g[2].logByte[n]), 32'(expByte(2, n)));
      check($sformatf("stale byte %0d", n), 32'(g[3].logByte[n]), 32'(expByte(3, n)));
      check($sformatf("lat2 sel %0d", n), 32'(g[2].logSel[n]), 32'(codeList[n/4]));
    end

    runDumpA("restart", 1'b1, 1'b0);

    clearLogs();
    pulseStart(1'b0);
    hits = 0;
    for (int k = 0; k < 2000; k++) begin
      if (g[0].txStart && g[0].muxSel == 7'h21) begin
        hits++;
        if (hits == 3) break;
      end
      @(negedge clk);
    end
    if (hits != 3) check("abort locate timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    abortA = 1'b1;
    @(negedge clk);
    abortA = 1'b0;
    check("abort busy", 32'(g[0].busy), 32'd0);
    check("abort tx_start", 32'(g[0].txStart), 32'd0);
    check("abort done", 32'(g[0].done), 32'd0);
    check("abort mux_sel", 32'(g[0].muxSel), 32'h21);
    repeat (30) @(negedge clk);
    check("abort byte count", 32'(g[0].n), 32'd39);
    check("abort no done", 32'(g[0].doneCnt), 32'd0);
    runDumpA("resume", 1'b0, 1'b0);

    clearLogs();
    pulseStart(1'b0);
    hits = 0;
    for (int k = 0; k < 2000; k++) begin
      if (g[0].txStart) begin
        hits++;
        if (hits == 5) break;
      end
      @(negedge clk);
    end
    if (hits != 5) check("reset locate timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("pre-reset tx_data", 32'(g[0].txData), 32'h01);
    check("pre-reset busy", 32'(g[0].busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async reset mux_sel", 32'(g[0].muxSel), 32'h00);
    check("async reset tx_start", 32'(g[0].txStart), 32'd0);
    check("async reset tx_data", 32'(g[0].txData), 32'h00);
    check("async reset busy", 32'(g[0].busy), 32'd0);
    check("async reset done", 32'(g[0].done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    runDumpA("post-reset", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
